// File: rtl/dsm_pkg.sv
// Shared defaults and the order encoding for the dsm_mod2 delta-sigma modulator.
package dsm_pkg;
    localparam int DSM_W = 16;
    localparam int DSM_G = 4;
    localparam int DSM_K = 8;

    localparam logic DSM_ORD1 = 1'b0;
    localparam logic DSM_ORD2 = 1'b1;
endpackage

// File: rtl/dsm_integrator.sv
// Saturating signed accumulator. The clamped next value is exported combinationally
// so a following stage can chain off it within the same advance cycle.
module dsm_integrator #(
    parameter int N = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                clr,
    input  logic signed [N:0]   delta,
    output logic signed [N-1:0] sum,
    output logic                sat_hit
);
    localparam logic signed [N+1:0] MAXV = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] MINV = {3'b111, {(N-1){1'b0}}};

    logic signed [N-1:0] acc;
    logic signed [N+1:0] raw;

    // Two extra bits hold acc + delta without wrap before clamping.
    assign raw = {{2{acc[N-1]}}, acc} + {delta[N], delta};

    always_comb begin
        sum     = raw[N-1:0];
        sat_hit = 1'b0;
        if (raw > MAXV) begin
            sum     = MAXV[N-1:0];
            sat_hit = 1'b1;
        end else if (raw < MINV) begin
            sum     = MINV[N-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (ce) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/dsm_mod2.sv
// First/second order delta-sigma modulator with saturating integrators,
// sticky overflow flag and a windowed ones-density monitor.
module dsm_mod2
    import dsm_pkg::*;
#(
    parameter int W = DSM_W,
    parameter int G = DSM_G,
    parameter int K = DSM_K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic         order,
    input  logic [W-1:0] alpha,
    input  logic         clr_ovf,
    output logic         bit_out,
    output logic         ovf,
    output logic [K:0]   density,
    output logic         density_valid
);
    localparam int N = W + G + 1;
    localparam logic signed [N-1:0] THR = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

    logic                order_q;
    logic                restart;
    logic                adv;
    logic                ord2;
    logic signed [N:0]   fb;
    logic signed [N:0]   delta1;
    logic signed [N:0]   delta2;
    logic signed [N-1:0] s1;
    logic signed [N-1:0] s2;
    logic signed [N-1:0] q;
    logic                hit1;
    logic                hit2;
    logic                b;
    logic                clamp;
    logic [K-1:0]        wcnt;
    logic [K:0]          ones;
    logic [K:0]          ones_b;

    // An order change restarts the loop and takes priority over ce.
    assign restart = (order != order_q);
    assign adv     = ce & ~restart;
    assign ord2    = (order_q == DSM_ORD2);

    assign fb     = {{(N-W){1'b0}}, bit_out, {W{1'b0}}};
    assign delta1 = {{(N+1-W){1'b0}}, alpha} - fb;
    assign delta2 = {s1[N-1], s1} - fb;

    dsm_integrator #(.N(N)) u_i1 (
        .clk     (clk),
        .reset   (reset),
        .ce      (adv),
        .clr     (restart),
        .delta   (delta1),
        .sum     (s1),
        .sat_hit (hit1)
    );

    // Held at zero while running first order.
    dsm_integrator #(.N(N)) u_i2 (
        .clk     (clk),
        .reset   (reset),
        .ce      (adv & ord2),
        .clr     (restart | (order_q == DSM_ORD1)),
        .delta   (delta2),
        .sum     (s2),
        .sat_hit (hit2)
    );

    assign q      = ord2 ? s2 : s1;
    assign b      = (q >= THR);
    assign clamp  = hit1 | (hit2 & ord2);
    assign ones_b = ones + {{K{1'b0}}, b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_q       <= DSM_ORD1;
            bit_out       <= 1'b0;
            wcnt          <= '0;
            ones          <= '0;
            density       <= '0;
            density_valid <= 1'b0;
        end else if (restart) begin
            order_q       <= order;
            bit_out       <= 1'b0;
            wcnt          <= '0;
            ones          <= '0;
            density_valid <= 1'b0;
        end else if (adv) begin
            bit_out <= b;
            wcnt    <= wcnt + 1'b1;
            if (&wcnt) begin
                density       <= ones_b;
                density_valid <= 1'b1;
                ones          <= '0;
            end else begin
                ones          <= ones_b;
                density_valid <= 1'b0;
            end
        end else begin
            density_valid <= 1'b0;
        end
    end

    // Set has priority over clear so a clamp is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (adv & clamp) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dsm_mod2.sv
// Scoreboard bench for dsm_mod2: a stimulus process feeds an arithmetic model and
// queues expectations; a monitor process compares them against the DUT outputs.
module tb_dsm_mod2;
    localparam int    W    = 16;
    localparam int    G    = 4;
    localparam int    K    = 8;
    localparam longint FS   = 64'd1 << W;
    localparam longint T    = 64'd1 << (W - 1);
    localparam longint SMAX = (64'd1 << (W + G)) - 1;
    localparam longint SMIN = -(64'sd1 << (W + G));
    localparam int    WIN  = 1 << K;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    logic         order;
    logic [W-1:0] alpha;
    logic         clr_ovf;
    logic         bit_out;
    logic         ovf;
    logic [K:0]   density;
    logic         density_valid;

    dsm_mod2 #(.W(W), .G(G), .K(K)) dut (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .order         (order),
        .alpha         (alpha),
        .clr_ovf       (clr_ovf),
        .bit_out       (bit_out),
        .ovf           (ovf),
        .density       (density),
        .density_valid (density_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit ovf;
        bit dv;
    } exp_t;

    exp_t   bq[$];
    int     dq[$];
    int     passed = 0;
    int     total  = 0;
    int     last_density = -1;
    longint cyc = 0;
    longint last_dv_cyc = 0;
    longint dv_period = 0;

    // Reference model state.
    longint m_i1, m_i2;
    bit     m_bit, m_ovf, m_ordq;
    int     m_wcnt, m_ones;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    endtask

    function automatic longint clampv(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_bit = 0; m_ovf = 0; m_ordq = 0; m_wcnt = 0; m_ones = 0;
    endtask

    task automatic step(input bit c, input bit o, input logic [W-1:0] a, input bit clr);
        exp_t   e;
        bit     dv = 0;
        int     dens = 0;
        longint fb, n1, n2, s1, s2, qv;
        bit     hit;
        ce = c; order = o; alpha = a; clr_ovf = clr;
        if (o != m_ordq) begin
            m_ordq = o; m_i1 = 0; m_i2 = 0; m_bit = 0; m_wcnt = 0; m_ones = 0;
            if (clr) m_ovf = 0;
        end else if (c) begin
            fb  = m_bit ? FS : 0;
            n1  = m_i1 + longint'(a) - fb;
            s1  = clampv(n1);
            hit = (s1 != n1);
            if (m_ordq) begin
                n2  = m_i2 + s1 - fb;
                s2  = clampv(n2);
                hit = hit || (s2 != n2);
                qv  = s2;
            end else begin
                s2 = 0;
                qv = s1;
            end
            m_i1  = s1;
            m_i2  = s2;
            m_bit = (qv >= T);
            if (hit) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (m_wcnt == WIN - 1) begin
                dv = 1; dens = m_ones + int'(m_bit); m_ones = 0; m_wcnt = 0;
            end else begin
                m_ones += int'(m_bit); m_wcnt++;
            end
        end else if (clr) begin
            m_ovf = 0;
        end
        @(posedge clk); #1;
        e.b = m_bit; e.ovf = m_ovf; e.dv = dv;
        bq.push_back(e);
        if (dv) dq.push_back(dens);
    endtask

    // mode 0: ce always, 1: ce one cycle in four, 2: random ce
    task automatic run(input int n, input int mode, input bit o, input logic [W-1:0] a, input bit clr);
        for (int i = 0; i < n; i++) begin
            bit c;
            c = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 4 == 0) : 1'($urandom_range(0, 1));
            step(c, o, a, clr);
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Monitor: bit_out/ovf/density_valid every cycle, density whenever it is flagged valid.
    initial begin
        exp_t e;
        int   dexp;
        forever begin
            @(negedge clk);
            cyc++;
            if (bq.size() > 0) begin
                e = bq.pop_front();
                check("bit_out", bit_out, e.b);
                check("ovf", ovf, e.ovf);
                check("density_valid", density_valid, e.dv);
            end
            if (density_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    check("density_valid_unexpected", 1, 0);
                end else begin
                    dexp = dq.pop_front();
                    check("density", density, dexp);
                    last_density = int'(density);
                    dv_period = cyc - last_dv_cyc;
                    last_dv_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ord;
        reset = 1'b1; ce = 1'b0; order = 1'b0; alpha = '0; clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bit_out", bit_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_density", density, 0);
        check("rst_density_valid", density_valid, 0);
        reset = 1'b0;

        // Order 1, half scale: alternating bits, density 128.
        run(3 * WIN, 0, 0, 16'h8000, 0);
        settle();
        check("o1_half_density", last_density, 128);
        check("o1_half_ovf", ovf, 0);

        // Order 1, quarter scale: density 64.
        run(3 * WIN, 0, 0, 16'h4000, 0);
        settle();
        check("o1_quarter_density", last_density, 64);

        // Order 2, zero input (first step is the restart).
        run(3 * WIN + 1, 0, 1, 16'h0000, 0);
        settle();
        check("o2_zero_density", last_density, 0);

        // Order 2, quarter scale.
        run(3 * WIN, 0, 1, 16'h4000, 0);
        settle();
        check("o2_quarter_range", (last_density >= 63 && last_density <= 65), 1);
        check("o2_quarter_ovf", ovf, 0);

        // Order 2 near full scale saturates.
        run(4096, 0, 1, 16'hFFFF, 0);
        settle();
        check("o2_full_ovf_set", ovf, 1);

        // Restart does not clear ovf; clr_ovf does once stable.
        run(1, 0, 0, 16'h8000, 0);
        run(300, 0, 1, 16'h8000, 0);
        settle();
        check("ovf_sticky_restart", ovf, 1);
        run(1, 0, 1, 16'h8000, 1);
        run(50, 0, 1, 16'h8000, 0);
        settle();
        check("ovf_cleared", ovf, 0);

        // clr_ovf held while clamping: set must win on every clamp cycle.
        run(300, 0, 1, 16'hFFFF, 1);
        run(20, 0, 1, 16'hFFFF, 0);
        settle();
        check("ovf_set_wins", ovf, 1);

        // Asynchronous reset between edges.
        @(negedge clk); #2;
        reset = 1'b1; ce = 1'b0;
        #1;
        check("async_bit_out", bit_out, 0);
        check("async_ovf", ovf, 0);
        check("async_density", density, 0);
        check("async_density_valid", density_valid, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;

        // Order toggle mid-window with ce high.
        run(100, 0, 1, 16'h4000, 0);
        run(WIN + 20, 0, 0, 16'h4000, 0);

        // ce gated 1-in-4: window stretches to 4*2^K clocks, density unchanged.
        run(3 * 4 * WIN, 1, 0, 16'h8000, 0);
        settle();
        check("gated_density", last_density, 128);
        check("gated_window_len", dv_period, 4 * WIN);

        // Randomised traffic: random ce, alpha, clr_ovf and occasional order changes.
        ord = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) ord = ~ord;
            step(1'($urandom_range(0, 1)), ord, 16'($urandom_range(16'h2000, 16'hE000)),
                 ($urandom_range(0, 49) == 0));
        end
        settle();
        check("queues_drained", bq.size() + dq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dsm_mod2.md
# dsm_mod2

Parametrised delta-sigma modulator and successor to the fixed 16-bit first-order modulator. It is selectable between first and second order at run time, and has configurable input width and integrator guard bits. Integrators saturate, and overflow is flagged in a sticky status bit. A windowed ones-density monitor supports on-chip and bench checking. It sits between the DAC code source and the 1-bit output driver.

## Interface
- `W`, 16, width of unsigned input code `alpha`; full scale is 2^W
- `G`, 4, integrator guard bits; integrators are signed, W+G+1 bits wide
- `K`, 8, density window is 2^K `ce` cycles
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `ce` in 1: modulator advance strobe (oversampling clock enable)
- `order` in 1: 0 = first order, 1 = second order
- `alpha` in W: unsigned input code; mean of `bit_out` = alpha/2^W
- `clr_ovf` in 1: synchronous clear of `ovf`
- `bit_out` out 1: modulator output bit, registered
- `ovf` out 1: sticky integrator saturation flag
- `density` out K+1: ones count of the last complete window
- `density_valid` out 1: one-cycle pulse when `density` updates

## Operation
- Feedback: fb = `bit_out` ? 2^W : 0. Threshold T = 2^(W-1).
- State:
  - `i1`, `i2`: signed W+G+1 integrators
  - `order_q`: registered order
  - `wcnt`: K-bit window counter
  - `ones`: K+1-bit ones accumulator
- Order 1, on `ce`:
  - n1 = i1 + alpha − fb
  - `i1` <= sat(n1)
  - `bit_out` <= (sat(n1) ≥ T)
  - `i2` held at 0
- Order 2, on `ce`:
  - n1 = i1 + alpha − fb
  - n2 = i2 + sat(n1) − fb
  - `i1` <= sat(n1), `i2` <= sat(n2)
  - `bit_out` <= (sat(n2) ≥ T)
  - This gives NTF (1−z⁻¹)².
- sat(): clamps to [−2^(W+G), 2^(W+G)−1].
  - Any clamp event in a `ce` cycle sets `ovf`.
  - `ovf` stays set until `clr_ovf` or `reset`.
  - A clamp and `clr_ovf` in the same cycle leave `ovf` = 1 (set wins).
- Order change:
  - Applies when `order` ≠ `order_q` in any cycle, regardless of `ce`.
  - Next edge: `order_q` <= `order`; `i1`, `i2`, `bit_out`, `wcnt`, `ones` <= 0.
  - No accumulation occurs in that cycle; restart wins over `ce`. `ovf` is unaffected.
- Density monitor, on each `ce` not overridden by restart, with b = the new `bit_out` value:
  - If `wcnt` = 2^K−1: `density` <= `ones` + b; `density_valid` <= 1; `ones` <= 0; `wcnt` wraps to 0.
  - Otherwise: `ones` <= `ones` + b; `wcnt` <= `wcnt` + 1.
- `alpha` is sampled combinationally on `ce` cycles. It is not registered.

## Timing
- Reset values: `bit_out` 0, `ovf` 0, `density` 0, `density_valid` 0; all internal state 0; `order_q` 0.
- Latency: `bit_out` reflects the `ce` cycle's `alpha` one edge after `ce`.
- Feedback uses the `bit_out` value present during that `ce` cycle.
- `ce` low: all state holds; `density_valid` is 0.
- `density_valid` is high for exactly one cycle per 2^K accepted `ce` cycles.
- `reset` asserted mid-window: everything clears immediately (asynchronous). Counting restarts at the first `ce` after release.
- Max `density` = 2^K, which needs the K+1 width.
- Stable input range for order 2 is roughly 0.1–0.9 of full scale. Outside that range saturation is expected and `ovf` reports it.

## Structure
- Package `dsm_pkg` holds:
  - default constants `DSM_W` = 16, `DSM_G` = 4, `DSM_K` = 8
  - the order encoding constants `DSM_ORD1` = 0 and `DSM_ORD2` = 1
- Sub-module `dsm_integrator` (parameter N):
  - ports: `clk`, `reset`, `ce`, `clr`, signed input, signed output, `sat_hit`
  - function: saturating accumulator
  - instanced twice
- The top level holds the quantiser, feedback, order-change control, `ovf` register and density monitor.

## Test plan
- Order 1, `alpha` = 0x8000, `ce` = 1: `bit_out` = 1,0,1,0… from the first edge after `ce`. `density` = 128 each window, `ovf` = 0.
- Order 1, `alpha` = 0x4000: `bit_out` period-4 pattern 0,1,0,0. `density` = 64 each window.
- Order 2, `alpha` = 0, and separately `alpha` = 0x4000:
  - 0: `bit_out` stays 0, `density` = 0.
  - 0x4000: `density` within 63–65 every window, `ovf` = 0.
- Order 2, `alpha` = 0xFFFF for 4096 cycles: `ovf` rises and stays 1.
  - `clr_ovf` pulse with `alpha` returned to 0x8000 after restart: `ovf` = 0.
  - Clamp and `clr_ovf` in the same cycle: `ovf` = 1.
- Toggle `order` mid-window with `ce` high: next edge clears `bit_out`, integrators and `wcnt`. The following `density_valid` occurs exactly 2^K `ce` cycles later.
- Assert `reset` asynchronously between edges: all outputs are 0 immediately. `ce` gated to 1-in-4: window length becomes 4×2^K clocks, and `density` values are unchanged.
